fp_mult_pipe: RTL and testbench

Parametrised, pipelined floating-point multiplier for the custom sign/exponent/fraction format. It is the successor to the fixed 12-bit multiplier, with these additions:
- configurable exponent and fraction widths;
- valid/ready handshaking with backpressure;
- selectable round-to-nearest-even or truncation;
- IEEE-style infinity/NaN handling and exception flags.

It sits between the operand-issue logic and the accumulate/writeback stage of the arithmetic datapath.

---
 rtl/fp_mult_pkg.sv | 37 +++
 rtl/fp_mult_if.sv | 29 ++
 rtl/fp_round.sv | 53 +++++
 rtl/fp_mult_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mult_pkg.sv
// Shared types and format helpers for the pipelined floating-point multiplier.
package fp_mult_pkg;

   // Operand classification after subnormal flush.
   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } fp_class_e;

   // Rounding selection, captured alongside the operands.
   typedef enum logic {
      RND_RNE   = 1'b0,
      RND_TRUNC = 1'b1
   } rnd_mode_e;

   // Exponent bias for an exponent field of exp_w bits.
   function automatic int bias(input int exp_w);
      return (32'sd1 <<< (exp_w - 1)) - 32'sd1;
   endfunction

   // Canonical quiet NaN: positive, all-ones exponent, fraction MSB set.
   function automatic logic [63:0] canonical_nan(input int exp_w, input int frac_w);
      logic [63:0] ones_e;
      ones_e = (64'd1 << exp_w) - 64'd1;
      return (ones_e << frac_w) | (64'd1 << (frac_w - 1));
   endfunction

   // Largest finite magnitude: exponent all-ones minus one, fraction all ones.
   function automatic logic [63:0] max_finite(input int exp_w, input int frac_w);
      logic [63:0] ones_e;
      ones_e = (64'd1 << exp_w) - 64'd1;
      return ((ones_e - 64'd1) << frac_w) | ((64'd1 << frac_w) - 64'd1);
   endfunction

endpackage

// File: rtl/fp_mult_if.sv
// Operand/result handshake bundle for fp_mult_pipe.
interface fp_mult_if #(
   parameter int EXP_W  = 5,
   parameter int FRAC_W = 6
) ();
   localparam int W = 1 + EXP_W + FRAC_W;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          rnd_mode;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic [3:0]    flags;

   // Issue side: drives operands, consumes results.
   modport master (
      output in_valid, a, b, rnd_mode, out_ready,
      input  in_ready, out_valid, result, flags
   );

   // Multiplier side.
   modport slave (
      input  in_valid, a, b, rnd_mode, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/fp_round.sv
// Combinational normalise-and-round of a raw mantissa product.
module fp_round #(
   parameter int FRAC_W = 6
) (
   input  logic [2*(FRAC_W+1)-1:0] prod_i,
   input  logic                    trunc_i,
   output logic [FRAC_W-1:0]       frac_o,
   output logic [1:0]              exp_inc_o,
   output logic                    inexact_o
);
   localparam int M  = FRAC_W + 1;
   localparam int PW = 2 * M;

   logic [PW-1:0] norm;
   logic [M-1:0]  mant;
   logic [M:0]    mant_r;
   logic          guard;
   logic          sticky;
   logic          round_up;

   // Align the leading one to the top, then round the kept M bits.
   always_comb begin
      norm      = {PW{1'b0}};
      mant      = {M{1'b0}};
      mant_r    = {(M+1){1'b0}};
      guard     = 1'b0;
      sticky    = 1'b0;
      round_up  = 1'b0;
      frac_o    = {FRAC_W{1'b0}};
      exp_inc_o = 2'd0;
      inexact_o = 1'b0;

      if (prod_i[PW-1]) begin
         norm = prod_i;
      end else begin
         norm = {prod_i[PW-2:0], 1'b0};
      end
      mant     = norm[PW-1 -: M];
      guard    = norm[M-1];
      sticky   = |norm[M-2:0];
      round_up = ~trunc_i & guard & (sticky | mant[0]);
      mant_r   = {1'b0, mant} + {{M{1'b0}}, round_up};

      // A carry out of the mantissa leaves 1.000..0 at the next binade.
      if (mant_r[M]) begin
         frac_o = {FRAC_W{1'b0}};
      end else begin
         frac_o = mant_r[FRAC_W-1:0];
      end
      exp_inc_o = {1'b0, prod_i[PW-1]} + {1'b0, mant_r[M]};
      inexact_o = guard | sticky;
   end
endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier with valid/ready flow control.
// A single global enable stalls every stage together when the result is
// not being taken, so bubbles are kept and the output holds steady.
module fp_mult_pipe
   import fp_mult_pkg::*;
#(
   parameter int EXP_W  = 5,
   parameter int FRAC_W = 6,
   parameter int SAT    = 1
) (
   input logic      clk,
   input logic      rst,
   fp_mult_if.slave bus
);
   localparam int W  = 1 + EXP_W + FRAC_W;
   localparam int M  = FRAC_W + 1;
   localparam int PW = 2 * M;
   localparam int E2 = EXP_W + 2;

   localparam logic [63:0]          NAN_FULL   = canonical_nan(EXP_W, FRAC_W);
   localparam logic [63:0]          MAXF_FULL  = max_finite(EXP_W, FRAC_W);
   localparam logic [W-1:0]         NAN_V      = NAN_FULL[W-1:0];
   localparam logic [W-2:0]         MAXF_MAG   = MAXF_FULL[W-2:0];
   localparam logic [EXP_W-1:0]     EXP_ONES   = {EXP_W{1'b1}};
   localparam logic signed [E2-1:0] BIAS_S     = E2'(bias(EXP_W));
   localparam logic signed [E2-1:0] EXP_ONES_S = $signed({2'b00, EXP_ONES});
   localparam logic signed [E2-1:0] EXP_ZERO_S = {E2{1'b0}};

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                          input logic [FRAC_W-1:0] f);
      fp_class_e c;
      if (e == {EXP_W{1'b0}}) begin
         c = CLS_ZERO;
      end else if (e == EXP_ONES) begin
         c = (f == {FRAC_W{1'b0}}) ? CLS_INF : CLS_NAN;
      end else begin
         c = CLS_NORM;
      end
      return c;
   endfunction

   logic en;

   // Stage 1: unpacked operands and their classes.
   logic               sa, sb;
   logic [EXP_W-1:0]   ea, eb;
   logic [FRAC_W-1:0]  fa, fb;
   fp_class_e          cls_a, cls_b;

   logic               v1_q;
   logic               sign1_d, sign1_q;
   logic               special1_d, special1_q;
   logic [W-1:0]       spec_res1_d, spec_res1_q;
   logic               spec_inv1_d, spec_inv1_q;
   logic [PW-1:0]      prod1_d, prod1_q;
   logic signed [E2-1:0] exp1_d, exp1_q;
   rnd_mode_e          rnd1_d, rnd1_q;

   // Stage 2: rounded fields.
   logic [FRAC_W-1:0]  rfrac;
   logic [1:0]         rexp_inc;
   logic               rinexact;

   logic               v2_q;
   logic               sign2_q;
   logic               special2_q;
   logic [W-1:0]       spec_res2_q;
   logic               spec_inv2_q;
   logic signed [E2-1:0] exp2_d, exp2_q;
   logic [FRAC_W-1:0]  frac2_q;
   logic               inexact2_q;

   // Stage 3: packed output.
   logic               v3_q;
   logic [W-1:0]       result3_d, result_q;
   logic [3:0]         flags3_d, flags_q;

   assign en            = ~v3_q | bus.out_ready;
   assign bus.in_ready  = en;
   assign bus.out_valid = v3_q;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;

   assign sa    = bus.a[W-1];
   assign ea    = bus.a[W-2:FRAC_W];
   assign fa    = bus.a[FRAC_W-1:0];
   assign sb    = bus.b[W-1];
   assign eb    = bus.b[W-2:FRAC_W];
   assign fb    = bus.b[FRAC_W-1:0];
   assign cls_a = classify(ea, fa);
   assign cls_b = classify(eb, fb);

   // Stage 1 logic: resolve special operands, form exponent sum and product.
   always_comb begin
      sign1_d     = sa ^ sb;
      special1_d  = 1'b1;
      spec_res1_d = NAN_V;
      spec_inv1_d = 1'b0;
      if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
         spec_res1_d = NAN_V;
      end else if ((cls_a == CLS_ZERO && cls_b == CLS_INF) ||
                   (cls_a == CLS_INF && cls_b == CLS_ZERO)) begin
         spec_inv1_d = 1'b1;
      end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
         spec_res1_d = {sign1_d, EXP_ONES, {FRAC_W{1'b0}}};
      end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
         spec_res1_d = {sign1_d, {(W-1){1'b0}}};
      end else begin
         special1_d  = 1'b0;
         spec_res1_d = {W{1'b0}};
      end
      prod1_d = {{M{1'b0}}, 1'b1, fa} * {{M{1'b0}}, 1'b1, fb};
      exp1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
      rnd1_d  = rnd_mode_e'(bus.rnd_mode);
   end

   // Stage 1 register.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q        <= 1'b0;
         sign1_q     <= 1'b0;
         special1_q  <= 1'b0;
         spec_res1_q <= {W{1'b0}};
         spec_inv1_q <= 1'b0;
         prod1_q     <= {PW{1'b0}};
         exp1_q      <= {E2{1'b0}};
         rnd1_q      <= RND_RNE;
      end else if (en) begin
         v1_q        <= bus.in_valid;
         sign1_q     <= sign1_d;
         special1_q  <= special1_d;
         spec_res1_q <= spec_res1_d;
         spec_inv1_q <= spec_inv1_d;
         prod1_q     <= prod1_d;
         exp1_q      <= exp1_d;
         rnd1_q      <= rnd1_d;
      end
   end

   fp_round #(
      .FRAC_W (FRAC_W)
   ) u_round (
      .prod_i    (prod1_q),
      .trunc_i   (rnd1_q == RND_TRUNC),
      .frac_o    (rfrac),
      .exp_inc_o (rexp_inc),
      .inexact_o (rinexact)
   );

   assign exp2_d = exp1_q + $signed({{(E2-2){1'b0}}, rexp_inc});

   // Stage 2 register.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_q        <= 1'b0;
         sign2_q     <= 1'b0;
         special2_q  <= 1'b0;
         spec_res2_q <= {W{1'b0}};
         spec_inv2_q <= 1'b0;
         exp2_q      <= {E2{1'b0}};
         frac2_q     <= {FRAC_W{1'b0}};
         inexact2_q  <= 1'b0;
      end else if (en) begin
         v2_q        <= v1_q;
         sign2_q     <= sign1_q;
         special2_q  <= special1_q;
         spec_res2_q <= spec_res1_q;
         spec_inv2_q <= spec_inv1_q;
         exp2_q      <= exp2_d;
         frac2_q     <= rfrac;
         inexact2_q  <= rinexact;
      end
   end

   // Stage 3 logic: range check and pack; flags are {inv, ovf, unf, inx}.
   always_comb begin
      result3_d = {W{1'b0}};
      flags3_d  = 4'b0000;
      if (special2_q) begin
         result3_d = spec_res2_q;
         flags3_d  = {spec_inv2_q, 3'b000};
      end else if (exp2_q >= EXP_ONES_S) begin
         flags3_d = 4'b0101;
         if (SAT != 0) begin
            result3_d = {sign2_q, MAXF_MAG};
         end else begin
            result3_d = {sign2_q, EXP_ONES, {FRAC_W{1'b0}}};
         end
      end else if (exp2_q <= EXP_ZERO_S) begin
         result3_d = {sign2_q, {(W-1){1'b0}}};
         flags3_d  = 4'b0011;
      end else begin
         result3_d = {sign2_q, exp2_q[EXP_W-1:0], frac2_q};
         flags3_d  = {3'b000, inexact2_q};
      end
   end

   // Stage 3 register, which is also the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         v3_q     <= 1'b0;
         result_q <= {W{1'b0}};
         flags_q  <= 4'b0000;
      end else if (en) begin
         v3_q     <= v2_q;
         result_q <= result3_d;
         flags_q  <= flags3_d;
      end
   end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: a saturating and a non-saturating instance share
// stimulus; expected results are queued at handshake and checked on output.
module tb_fp_mult_pipe;
   localparam int W = 12;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         rnd;
      logic [W-1:0] r1;
      logic [3:0]   f1;
      logic [W-1:0] r0;
      logic [3:0]   f0;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         out_ready;
   logic         rnd;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [15:0]  cur1;
   logic [15:0]  cur0;
   logic [15:0]  q1[$];
   logic [15:0]  q0[$];
   logic         prev_stall;
   logic [15:0]  prev_out;
   int           total = 0;
   int           bad = 0;
   int           n_out = 0;
   vec_t         tbl[$];

   always #5 clk = ~clk;

   fp_mult_if #(.EXP_W(5), .FRAC_W(6)) bus1 ();
   fp_mult_if #(.EXP_W(5), .FRAC_W(6)) bus0 ();

   assign bus1.in_valid  = in_valid;
   assign bus1.a         = a;
   assign bus1.b         = b;
   assign bus1.rnd_mode  = rnd;
   assign bus1.out_ready = out_ready;
   assign bus0.in_valid  = in_valid;
   assign bus0.a         = a;
   assign bus0.b         = b;
   assign bus0.rnd_mode  = rnd;
   assign bus0.out_ready = out_ready;

   fp_mult_pipe #(.EXP_W(5), .FRAC_W(6), .SAT(1)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   fp_mult_pipe #(.EXP_W(5), .FRAC_W(6), .SAT(0)) dut_inf (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   function automatic vec_t mk(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                               input logic rnd_v,
                               input logic [W-1:0] r1_v, input logic [3:0] f1_v,
                               input logic [W-1:0] r0_v, input logic [3:0] f0_v);
      vec_t v;
      v.a = a_v; v.b = b_v; v.rnd = rnd_v;
      v.r1 = r1_v; v.f1 = f1_v; v.r0 = r0_v; v.f0 = f0_v;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp_v);
      end
   endtask

   // Scoreboard monitor: push on accept, pop and compare on output transfer.
   always @(negedge clk) begin
      if (rst) begin
         q1.delete();
         q0.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", {15'd0, bus1.out_valid}, 16'd1);
            chk("hold_data", {bus1.flags, bus1.result}, prev_out);
         end
         if (bus1.out_valid && !bus1.out_ready)
            chk("stall_in_ready", {15'd0, bus1.in_ready}, 16'd0);
         if (bus1.in_valid && bus1.in_ready) q1.push_back(cur1);
         if (bus0.in_valid && bus0.in_ready) q0.push_back(cur0);
         if (bus1.out_valid && bus1.out_ready) begin
            n_out++;
            if (q1.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_out_sat: got %h", {bus1.flags, bus1.result});
            end else begin
               chk("res_sat", {bus1.flags, bus1.result}, q1.pop_front());
            end
         end
         if (bus0.out_valid && bus0.out_ready) begin
            if (q0.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_out_inf: got %h", {bus0.flags, bus0.result});
            end else begin
               chk("res_inf", {bus0.flags, bus0.result}, q0.pop_front());
            end
         end
         prev_stall = bus1.out_valid && !bus1.out_ready;
         prev_out   = {bus1.flags, bus1.result};
      end
   end

   // Present one operand pair and wait (bounded) for it to be accepted.
   task automatic send(input vec_t v);
      int n;
      a = v.a; b = v.b; rnd = v.rnd;
      cur1 = {v.f1, v.r1};
      cur0 = {v.f0, v.r0};
      in_valid = 1'b1;
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (bus1.in_ready) break;
         n++;
      end
      if (n >= 50) begin
         total++; bad++;
         $display("FAIL send_timeout: in_ready stuck 0 for %0d cycles", n);
      end
      @(posedge clk); #1;
   endtask

   // Wait (bounded) until every queued expectation has been matched.
   task automatic drain();
      int n;
      n = 0;
      while (n < 60 && (q1.size() != 0 || q0.size() != 0)) begin
         @(negedge clk);
         n++;
      end
      chk("drain_sat", 16'(q1.size()), 16'd0);
      chk("drain_inf", 16'(q0.size()), 16'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int base;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rnd = 1'b0;
      a = 12'h000; b = 12'h000; cur1 = 16'h0000; cur0 = 16'h0000;
      prev_stall = 1'b0; prev_out = 16'h0000;

      //           a       b       rnd   SAT=1 res/flags   SAT=0 res/flags
      tbl.push_back(mk(12'h3E0, 12'h3E0, 1'b0, 12'h408, 4'h0, 12'h408, 4'h0));
      tbl.push_back(mk(12'hC00, 12'h3E0, 1'b0, 12'hC20, 4'h0, 12'hC20, 4'h0));
      tbl.push_back(mk(12'h3C1, 12'h3E0, 1'b0, 12'h3E2, 4'h1, 12'h3E2, 4'h1));
      tbl.push_back(mk(12'h3C1, 12'h3E0, 1'b1, 12'h3E1, 4'h1, 12'h3E1, 4'h1));
      tbl.push_back(mk(12'h7BF, 12'h7BF, 1'b0, 12'h7BF, 4'h5, 12'h7C0, 4'h5));
      tbl.push_back(mk(12'h840, 12'h040, 1'b0, 12'h800, 4'h3, 12'h800, 4'h3));
      tbl.push_back(mk(12'h000, 12'h7C0, 1'b0, 12'h7E0, 4'h8, 12'h7E0, 4'h8));
      tbl.push_back(mk(12'h7E5, 12'h3C0, 1'b0, 12'h7E0, 4'h0, 12'h7E0, 4'h0));
      tbl.push_back(mk(12'hC40, 12'h040, 1'b0, 12'h8C0, 4'h0, 12'h8C0, 4'h0));
      tbl.push_back(mk(12'h3E0, 12'h3D5, 1'b0, 12'h400, 4'h1, 12'h400, 4'h1));
      tbl.push_back(mk(12'h3E0, 12'h3D5, 1'b1, 12'h3FF, 4'h1, 12'h3FF, 4'h1));
      tbl.push_back(mk(12'hFC0, 12'h3C0, 1'b0, 12'hFC0, 4'h0, 12'hFC0, 4'h0));
      tbl.push_back(mk(12'h7C0, 12'hFC0, 1'b0, 12'hFC0, 4'h0, 12'hFC0, 4'h0));
      tbl.push_back(mk(12'h7C0, 12'h800, 1'b0, 12'h7E0, 4'h8, 12'h7E0, 4'h8));
      tbl.push_back(mk(12'h800, 12'h3C0, 1'b0, 12'h800, 4'h0, 12'h800, 4'h0));
      tbl.push_back(mk(12'h001, 12'h3C0, 1'b0, 12'h000, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(12'h780, 12'h3C0, 1'b0, 12'h780, 4'h0, 12'h780, 4'h0));
      tbl.push_back(mk(12'h780, 12'h400, 1'b0, 12'h7BF, 4'h5, 12'h7C0, 4'h5));
      tbl.push_back(mk(12'h040, 12'h3C0, 1'b0, 12'h040, 4'h0, 12'h040, 4'h0));
      tbl.push_back(mk(12'h040, 12'h380, 1'b0, 12'h000, 4'h3, 12'h000, 4'h3));
      tbl.push_back(mk(12'h7BF, 12'h7BF, 1'b1, 12'h7BF, 4'h5, 12'h7C0, 4'h5));
      tbl.push_back(mk(12'h7C1, 12'h7C0, 1'b0, 12'h7E0, 4'h0, 12'h7E0, 4'h0));
      tbl.push_back(mk(12'hFE0, 12'h000, 1'b0, 12'h7E0, 4'h0, 12'h7E0, 4'h0));

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {15'd0, bus1.out_valid}, 16'd0);
      chk("rst_result", {4'h0, bus1.result}, 16'h0000);
      chk("rst_flags", {12'h000, bus1.flags}, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rel_in_ready", {15'd0, bus1.in_ready}, 16'd1);
      chk("rel_out_valid", {15'd0, bus1.out_valid}, 16'd0);

      // Latency: one operation, out_valid rises on the third edge after accept.
      @(posedge clk); #1;
      a = tbl[0].a; b = tbl[0].b; rnd = tbl[0].rnd;
      cur1 = {tbl[0].f1, tbl[0].r1}; cur0 = {tbl[0].f0, tbl[0].r0};
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_c1", {15'd0, bus1.out_valid}, 16'd0);
      @(negedge clk);
      chk("lat_c2", {15'd0, bus1.out_valid}, 16'd0);
      @(negedge clk);
      chk("lat_c3", {15'd0, bus1.out_valid}, 16'd1);
      drain();

      // Whole table back to back.
      for (int i = 0; i < tbl.size(); i++) send(tbl[i]);
      in_valid = 1'b0;
      drain();

      // Backpressure: out_ready low for cycles 4..7 of a six-operation stream.
      base = n_out;
      fork
         begin
            for (int c = 0; c < 14; c++) begin
               out_ready = !(c >= 4 && c <= 7);
               @(posedge clk); #1;
            end
         end
         begin
            for (int i = 0; i < 6; i++) send(tbl[i]);
            in_valid = 1'b0;
         end
      join
      out_ready = 1'b1;
      drain();
      chk("bp_count", 16'(n_out - base), 16'd6);

      // Reset in the middle of a stream discards everything in flight.
      for (int i = 6; i < 10; i++) send(tbl[i]);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_rst_valid_sat", {15'd0, bus1.out_valid}, 16'd0);
      chk("mid_rst_valid_inf", {15'd0, bus0.out_valid}, 16'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rel_in_ready", {15'd0, bus1.in_ready}, 16'd1);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("no_stale", {15'd0, bus1.out_valid}, 16'd0);
      end
      @(posedge clk); #1;
      send(tbl[4]);
      in_valid = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
